// File: rtl/alu_dmem_stage_if.sv
// alu_dmem_stage_if: operand, control and result bundle of the execute/memory stage
interface alu_dmem_stage_if;
    logic [1:0]  alu_op;
    logic [3:0]  opcode;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] write_data;
    logic        mem_write;
    logic        mem_read;
    logic [2:0]  alu_control;
    logic [15:0] alu_result;
    logic        zero;
    logic [15:0] read_data;
    modport master (
        output alu_op, opcode, a, b, write_data, mem_write, mem_read,
        input  alu_control, alu_result, zero, read_data
    );
    modport slave (
        input  alu_op, opcode, a, b, write_data, mem_write, mem_read,
        output alu_control, alu_result, zero, read_data
    );
endinterface

// File: rtl/alu_dmem_stage.sv
// alu_dmem_stage: ALU decode/execute plus a 256x16 data memory addressed by the ALU result
module alu_dmem_stage (
    input logic clk,
    input logic reset,
    alu_dmem_stage_if.slave bus
);
    logic [15:0] r_mem [256];
    logic [2:0]  w_ctl;
    logic [15:0] w_res;
    logic [7:0]  w_idx;
    logic        w_sh_big;
    // R-type opcodes 0010..1001 map linearly onto ALU ops 000..111
    always_comb begin
        w_ctl = 3'b000;
        if (bus.alu_op == 2'b01)
            w_ctl = 3'b001;
        else if (bus.alu_op == 2'b00 && bus.opcode >= 4'd2 && bus.opcode <= 4'd9)
            w_ctl = 3'(bus.opcode - 4'd2);
    end
    assign w_sh_big = |bus.b[15:4];
    always_comb begin
        w_res = '0;
        case (w_ctl)
            3'b000: w_res = bus.a + bus.b;
            3'b001: w_res = bus.a - bus.b;
            3'b010: w_res = ~bus.a;
            3'b011: w_res = w_sh_big ? 16'h0 : bus.a << bus.b[3:0];
            3'b100: w_res = w_sh_big ? 16'h0 : bus.a >> bus.b[3:0];
            3'b101: w_res = bus.a & bus.b;
            3'b110: w_res = bus.a | bus.b;
            3'b111: w_res = {15'b0, $signed(bus.a) < $signed(bus.b)};
            default: w_res = '0;
        endcase
    end
    // Word-aligned, aliasing every 512 bytes
    assign w_idx = w_res[8:1];
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++)
                r_mem[i] <= '0;
        end else if (bus.mem_write) begin
            r_mem[w_idx] <= bus.write_data;
        end
    end
    assign bus.alu_control = w_ctl;
    assign bus.alu_result  = w_res;
    assign bus.zero        = (w_res == 16'h0);
    assign bus.read_data   = bus.mem_read ? r_mem[w_idx] : 16'h0;
endmodule

// File: tb/tb_alu_dmem_stage.sv
// tb_alu_dmem_stage: directed checks of decode, ALU, flags and data memory
module tb_alu_dmem_stage;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int tests = 0;
    int fails = 0;
    alu_dmem_stage_if bus ();
    alu_dmem_stage dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic set_op(input logic [1:0] op, input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b);
        bus.alu_op = op;
        bus.opcode = opc;
        bus.a = a;
        bus.b = b;
        #1;
    endtask

    task automatic test_reset();
        bus.mem_write = 1'b0;
        bus.mem_read = 1'b1;
        bus.write_data = 16'h0;
        set_op(2'b10, 4'h0, 16'h0008, 16'h0008);
        reset = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (bus.read_data !== 16'h0) begin
            fails++;
            $display("FAIL reset_read got %h want 0000", bus.read_data);
        end
        tests++;
        if (bus.alu_result !== 16'h0010) begin
            fails++;
            $display("FAIL reset_alu got %h want 0010", bus.alu_result);
        end
        reset = 1'b1;
        bus.mem_read = 1'b0;
    endtask

    task automatic test_decode();
        logic [2:0] exp_dec [16];
        exp_dec = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
                    3'd6, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        for (int i = 0; i < 16; i++) begin
            set_op(2'b00, 4'(i), 16'h0, 16'h0);
            tests++;
            if (bus.alu_control !== exp_dec[i]) begin
                fails++;
                $display("FAIL decode_op%0d got %0d want %0d", i, bus.alu_control, exp_dec[i]);
            end
        end
        set_op(2'b10, 4'h4, 16'h0, 16'h0);
        tests++;
        if (bus.alu_control !== 3'd0) begin
            fails++;
            $display("FAIL decode_aluop10 got %0d want 0", bus.alu_control);
        end
        set_op(2'b01, 4'h4, 16'h0, 16'h0);
        tests++;
        if (bus.alu_control !== 3'd1) begin
            fails++;
            $display("FAIL decode_aluop01 got %0d want 1", bus.alu_control);
        end
        set_op(2'b11, 4'h4, 16'h0, 16'h0);
        tests++;
        if (bus.alu_control !== 3'd0) begin
            fails++;
            $display("FAIL decode_aluop11 got %0d want 0", bus.alu_control);
        end
    endtask

    task automatic test_arith();
        set_op(2'b10, 4'h0, 16'h7FFF, 16'h0001);
        tests++;
        if (bus.alu_result !== 16'h8000 || bus.zero !== 1'b0) begin
            fails++;
            $display("FAIL add_ovf got %h z=%b want 8000 z=0", bus.alu_result, bus.zero);
        end
        set_op(2'b10, 4'h0, 16'hFFFF, 16'h0001);
        tests++;
        if (bus.alu_result !== 16'h0000 || bus.zero !== 1'b1) begin
            fails++;
            $display("FAIL add_wrap got %h z=%b want 0000 z=1", bus.alu_result, bus.zero);
        end
        set_op(2'b01, 4'h0, 16'h0005, 16'h0005);
        tests++;
        if (bus.alu_result !== 16'h0000 || bus.zero !== 1'b1) begin
            fails++;
            $display("FAIL sub_eq got %h z=%b want 0000 z=1", bus.alu_result, bus.zero);
        end
        set_op(2'b00, 4'h3, 16'h0003, 16'h0005);
        tests++;
        if (bus.alu_result !== 16'hFFFE || bus.zero !== 1'b0) begin
            fails++;
            $display("FAIL sub_neg got %h z=%b want fffe z=0", bus.alu_result, bus.zero);
        end
    endtask

    task automatic test_logic_shift();
        set_op(2'b00, 4'h7, 16'h00F0, 16'h0FF0);
        tests++;
        if (bus.alu_result !== 16'h00F0) begin
            fails++;
            $display("FAIL and got %h want 00f0", bus.alu_result);
        end
        set_op(2'b00, 4'h8, 16'h00F0, 16'h0FF0);
        tests++;
        if (bus.alu_result !== 16'h0FF0) begin
            fails++;
            $display("FAIL or got %h want 0ff0", bus.alu_result);
        end
        set_op(2'b00, 4'h4, 16'h00F0, 16'h1234);
        tests++;
        if (bus.alu_result !== 16'hFF0F) begin
            fails++;
            $display("FAIL not got %h want ff0f", bus.alu_result);
        end
        set_op(2'b00, 4'h5, 16'h0001, 16'd15);
        tests++;
        if (bus.alu_result !== 16'h8000) begin
            fails++;
            $display("FAIL shl15 got %h want 8000", bus.alu_result);
        end
        set_op(2'b00, 4'h5, 16'h0001, 16'd16);
        tests++;
        if (bus.alu_result !== 16'h0000 || bus.zero !== 1'b1) begin
            fails++;
            $display("FAIL shl16 got %h z=%b want 0000 z=1", bus.alu_result, bus.zero);
        end
        set_op(2'b00, 4'h6, 16'h8000, 16'd15);
        tests++;
        if (bus.alu_result !== 16'h0001) begin
            fails++;
            $display("FAIL shr15 got %h want 0001", bus.alu_result);
        end
        set_op(2'b00, 4'h6, 16'h8000, 16'h0100);
        tests++;
        if (bus.alu_result !== 16'h0000) begin
            fails++;
            $display("FAIL shr_big got %h want 0000", bus.alu_result);
        end
        set_op(2'b00, 4'h9, 16'hFFFF, 16'h0001);
        tests++;
        if (bus.alu_result !== 16'h0001) begin
            fails++;
            $display("FAIL slt_neg got %h want 0001", bus.alu_result);
        end
        set_op(2'b00, 4'h9, 16'h0001, 16'hFFFF);
        tests++;
        if (bus.alu_result !== 16'h0000 || bus.zero !== 1'b1) begin
            fails++;
            $display("FAIL slt_pos got %h z=%b want 0000 z=1", bus.alu_result, bus.zero);
        end
    endtask

    task automatic test_memory();
        @(negedge clk);
        set_op(2'b10, 4'h0, 16'h0008, 16'h0008);
        bus.write_data = 16'hABCD;
        bus.mem_write = 1'b1;
        @(posedge clk); #1;
        bus.mem_write = 1'b0;
        bus.mem_read = 1'b1;
        #1;
        tests++;
        if (bus.read_data !== 16'hABCD) begin
            fails++;
            $display("FAIL load_0010 got %h want abcd", bus.read_data);
        end
        set_op(2'b10, 4'h0, 16'h0008, 16'h0009);
        tests++;
        if (bus.read_data !== 16'hABCD) begin
            fails++;
            $display("FAIL load_0011 got %h want abcd", bus.read_data);
        end
        set_op(2'b10, 4'h0, 16'h0208, 16'h0008);
        tests++;
        if (bus.read_data !== 16'hABCD) begin
            fails++;
            $display("FAIL load_0210 got %h want abcd", bus.read_data);
        end
        set_op(2'b10, 4'h0, 16'h0008, 16'h000A);
        tests++;
        if (bus.read_data !== 16'h0000) begin
            fails++;
            $display("FAIL load_0012 got %h want 0000", bus.read_data);
        end
        set_op(2'b10, 4'h0, 16'h0008, 16'h0008);
        bus.mem_read = 1'b0;
        #1;
        tests++;
        if (bus.read_data !== 16'h0000) begin
            fails++;
            $display("FAIL load_noread got %h want 0000", bus.read_data);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        set_op(2'b10, 4'h0, 16'h0010, 16'h0010);
        bus.write_data = 16'h1111;
        bus.mem_write = 1'b1;
        bus.mem_read = 1'b0;
        @(negedge clk);
        bus.write_data = 16'h2222;
        bus.mem_read = 1'b1;
        #1;
        tests++;
        if (bus.read_data !== 16'h1111) begin
            fails++;
            $display("FAIL rw_before got %h want 1111", bus.read_data);
        end
        @(posedge clk); #1;
        bus.mem_write = 1'b0;
        #1;
        tests++;
        if (bus.read_data !== 16'h2222) begin
            fails++;
            $display("FAIL rw_after got %h want 2222", bus.read_data);
        end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        set_op(2'b10, 4'h0, 16'h0002, 16'h0002);
        bus.write_data = 16'h1234;
        bus.mem_write = 1'b1;
        bus.mem_read = 1'b0;
        @(negedge clk);
        bus.mem_write = 1'b0;
        bus.mem_read = 1'b1;
        #1;
        tests++;
        if (bus.read_data !== 16'h1234) begin
            fails++;
            $display("FAIL pre_reset got %h want 1234", bus.read_data);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.write_data = 16'h5555;
        bus.mem_write = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (bus.read_data !== 16'h0000) begin
            fails++;
            $display("FAIL reset_write got %h want 0000", bus.read_data);
        end
        reset = 1'b1;
        bus.mem_write = 1'b0;
        #1;
        tests++;
        if (bus.read_data !== 16'h0000) begin
            fails++;
            $display("FAIL post_reset_0004 got %h want 0000", bus.read_data);
        end
        set_op(2'b10, 4'h0, 16'h0010, 16'h0010);
        tests++;
        if (bus.read_data !== 16'h0000) begin
            fails++;
            $display("FAIL post_reset_0020 got %h want 0000", bus.read_data);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_arith();
        test_logic_shift();
        test_memory();
        test_back_to_back();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
